fast_square_sweep_ctrl: RTL and testbench

Timing sequencer that drives the fast-square receive chain through a frequency sweep.
It generates the rx-chain reset, `record` and `freq_step` strobes consumed directly by the fast-square receiver/accumulator stage.
It is configured over the standard serial settings bus (`serial_addr`/`serial_data`/`serial_strobe`).

---
 rtl/fast_square_sweep_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_fast_square_sweep_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fast_square_sweep_ctrl.sv
// fast_square_sweep_ctrl
//
// Timing sequencer for the fast-square receive chain frequency sweep.
// Each sweep point runs: settle -> record (2^RECORD_TICKS_LOG2 cycles)
// -> one-cycle freq_step -> gap. A sweep is preceded by a two-cycle
// rx_reset (INIT) and optionally waits for an external trigger edge.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high
//   serial_addr   settings bus address (7 bits)
//   serial_data   settings bus data (32 bits)
//   serial_strobe settings bus write strobe
//   ext_trigger   asynchronous external sweep trigger
//   rx_reset      receiver reset (re-latches frequency settings)
//   record        high during the record window
//   freq_step     one-cycle pulse: latch sums, advance frequency
//   busy          high in every state except IDLE
//   step_idx      0-based index of the current sweep point
//   sweep_done    one-cycle pulse in the last GAP cycle of a sweep
//
// Settings bus handshake: a write is a single cycle with serial_strobe
// high; addr/data are sampled on that clock edge. There is no back-pressure.
//
// Register map (reset value 0):
//   CTRLADDR   : [1] continuous, [2] ext_trig_en, [15:8] num_steps (0 => 1)
//                a write with [0]=1 starts/restarts, [0]=0 aborts
//   TIMINGADDR : [15:0] settle_ticks, [31:16] gap_ticks

module fast_square_sweep_ctrl #(
    parameter int CTRLADDR          = 3,
    parameter int TIMINGADDR        = 4,
    parameter int RECORD_TICKS_LOG2 = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic        ext_trigger,
    output logic        rx_reset,
    output logic        record,
    output logic        freq_step,
    output logic        busy,
    output logic [7:0]  step_idx,
    output logic        sweep_done
);

    typedef enum logic [2:0] {
        IDLE, INIT, WAIT_TRIG, SETTLE, RECORD, STEP, GAP
    } state_t;

    state_t state;

    // Settings registers; only the fields the sequencer uses are stored.
    logic        cont_reg;
    logic        trig_en_reg;
    logic [7:0]  num_steps_reg;
    logic [15:0] settle_reg;
    logic [15:0] gap_reg;

    logic ctrl_wr;
    logic timing_wr;
    assign ctrl_wr   = serial_strobe && (serial_addr == 7'(CTRLADDR));
    assign timing_wr = serial_strobe && (serial_addr == 7'(TIMINGADDR));

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_reg      <= 1'b0;
            trig_en_reg   <= 1'b0;
            num_steps_reg <= 8'd0;
            settle_reg    <= 16'd0;
            gap_reg       <= 16'd0;
        end else begin
            if (ctrl_wr) begin
                cont_reg      <= serial_data[1];
                trig_en_reg   <= serial_data[2];
                num_steps_reg <= serial_data[15:8];
            end
            if (timing_wr) begin
                settle_reg <= serial_data[15:0];
                gap_reg    <= serial_data[31:16];
            end
        end
    end

    // A step count of zero still runs one point.
    logic [7:0] num_steps;
    logic [7:0] next_idx;
    assign num_steps = (num_steps_reg == 8'd0) ? 8'd1 : num_steps_reg;
    assign next_idx  = step_idx + 8'd1;

    // Two-flop synchronizer followed by a rising-edge detector.
    logic trig_s1, trig_s2, trig_prev, trig_edge;
    always_ff @(posedge clock) begin
        if (reset) begin
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_s1   <= ext_trigger;
            trig_s2   <= trig_s1;
            trig_prev <= trig_s2;
        end
    end
    assign trig_edge = trig_s2 && !trig_prev;

    // cnt is shared: INIT length, SETTLE and GAP. rec_cnt times RECORD.
    logic [15:0]                  cnt;
    logic [RECORD_TICKS_LOG2-1:0] rec_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rx_reset   <= 1'b0;
            record     <= 1'b0;
            freq_step  <= 1'b0;
            busy       <= 1'b0;
            step_idx   <= 8'd0;
            sweep_done <= 1'b0;
            cnt        <= 16'd0;
            rec_cnt    <= '0;
        end else if (ctrl_wr) begin
            // Start or abort takes priority over whatever is in flight.
            record     <= 1'b0;
            freq_step  <= 1'b0;
            sweep_done <= 1'b0;
            step_idx   <= 8'd0;
            cnt        <= 16'd1;
            rec_cnt    <= '0;
            if (serial_data[0]) begin
                state    <= INIT;
                rx_reset <= 1'b1;
                busy     <= 1'b1;
            end else begin
                state    <= IDLE;
                rx_reset <= 1'b0;
                busy     <= 1'b0;
            end
        end else begin
            freq_step  <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: ;
                INIT: begin
                    if (cnt == 16'd0) begin
                        rx_reset <= 1'b0;
                        if (trig_en_reg) begin
                            state <= WAIT_TRIG;
                        end else begin
                            state <= SETTLE;
                            cnt   <= settle_reg;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                WAIT_TRIG: begin
                    if (trig_edge) begin
                        state <= SETTLE;
                        cnt   <= settle_reg;
                    end
                end
                SETTLE: begin
                    if (cnt == 16'd0) begin
                        state   <= RECORD;
                        record  <= 1'b1;
                        rec_cnt <= '0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                RECORD: begin
                    if (&rec_cnt) begin
                        state     <= STEP;
                        record    <= 1'b0;
                        freq_step <= 1'b1;
                    end else begin
                        rec_cnt <= rec_cnt + 1'b1;
                    end
                end
                STEP: begin
                    state    <= GAP;
                    step_idx <= next_idx;
                    cnt      <= gap_reg;
                    // A zero-length gap is its own last cycle.
                    sweep_done <= (gap_reg == 16'd0) && (next_idx >= num_steps);
                end
                GAP: begin
                    if (cnt == 16'd0) begin
                        if (step_idx < num_steps) begin
                            state <= SETTLE;
                            cnt   <= settle_reg;
                        end else if (cont_reg) begin
                            state    <= INIT;
                            rx_reset <= 1'b1;
                            step_idx <= 8'd0;
                            cnt      <= 16'd1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt        <= cnt - 16'd1;
                        // Registered pulse lands on the cycle where cnt reaches 0.
                        sweep_done <= (cnt == 16'd1) && (step_idx >= num_steps);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rx_reset <= 1'b0;
                    record   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Bench for fast_square_sweep_ctrl with RECORD_TICKS_LOG2=4.
// Expected per-cycle output words {busy,rx_reset,record,freq_step,
// sweep_done,step_idx} are built from the sweep timeline and queued,
// then popped and compared one per clock at the falling edge.

module tb_fast_square_sweep_ctrl;

    localparam int RL    = 4;
    localparam int W     = 13;
    localparam int CADDR = 3;
    localparam int TADDR = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic        ext_trigger;
    logic        rx_reset, record, freq_step, busy, sweep_done;
    logic [7:0]  step_idx;

    always #5 clock = ~clock;

    fast_square_sweep_ctrl #(
        .CTRLADDR(CADDR), .TIMINGADDR(TADDR), .RECORD_TICKS_LOG2(RL)
    ) dut (
        .clock(clock), .reset(reset),
        .serial_addr(serial_addr), .serial_data(serial_data),
        .serial_strobe(serial_strobe), .ext_trigger(ext_trigger),
        .rx_reset(rx_reset), .record(record), .freq_step(freq_step),
        .busy(busy), .step_idx(step_idx), .sweep_done(sweep_done)
    );

    typedef struct {
        logic [31:0] timing;
        logic [31:0] ctrl;
        int          settle;
        int          gap;
        int          n;
    } vec_t;

    vec_t           tbl[3];
    logic [W-1:0]   exp_q[$];
    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    int             rec_seen = 0;
    int             done_seen = 0;
    logic           last_rec;

    function automatic logic [W-1:0] pk(bit b, bit r, bit rc, bit f, bit d, int i);
        return {b, r, rc, f, d, 8'(i)};
    endfunction

    task automatic push_n(int n, logic [W-1:0] v);
        repeat (n) exp_q.push_back(v);
    endtask

    // Expected trace of one sweep starting at INIT.
    task automatic gen_sweep(int s, int g, int n, bit cont);
        push_n(2, pk(1, 1, 0, 0, 0, 0));
        for (int p = 0; p < n; p++) begin
            push_n(s + 1, pk(1, 0, 0, 0, 0, p));
            push_n(16, pk(1, 0, 1, 0, 0, p));
            push_n(1, pk(1, 0, 0, 1, 0, p));
            push_n(g, pk(1, 0, 0, 0, 0, p + 1));
            push_n(1, pk(1, 0, 0, 0, (p == n - 1), p + 1));
        end
        if (!cont) push_n(3, pk(0, 0, 0, 0, 0, n));
    endtask

    // One clock: compare at negedge (if an expectation is queued), then
    // return just after the next rising edge.
    task automatic step();
        logic [W-1:0] got, e;
        @(negedge clock);
        got = {busy, rx_reset, record, freq_step, sweep_done, step_idx};
        last_rec = record;
        if (record) rec_seen++;
        if (sweep_done) done_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL trace cyc=%0d got=%h exp=%h", cyc, got, e);
            end
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic run_q();
        while (exp_q.size() > 0) step();
    endtask

    // Keep only the first `keep` queued entries and run up to the last one.
    task automatic run_prefix(int keep);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
        while (exp_q.size() > 1) step();
    endtask

    task automatic bus_write(int addr, logic [31:0] data);
        serial_addr   = 7'(addr);
        serial_data   = data;
        serial_strobe = 1'b1;
        step();
        serial_strobe = 1'b0;
    endtask

    task automatic check(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bit found;

        tbl[0] = '{32'h0002_0003, 32'h0000_0301, 3, 2, 3};
        tbl[1] = '{32'h0002_0003, 32'h0000_0001, 3, 2, 1};
        tbl[2] = '{32'h0001_0000, 32'h0000_0201, 0, 1, 2};

        reset = 1'b1;
        serial_addr = '0;
        serial_data = '0;
        serial_strobe = 1'b0;
        ext_trigger = 1'b0;
        @(posedge clock);
        #1;

        // Reset state, then idle.
        push_n(3, pk(0, 0, 0, 0, 0, 0));
        run_q();
        reset = 1'b0;
        push_n(10, pk(0, 0, 0, 0, 0, 0));
        run_q();

        // Table-driven single sweeps.
        for (int i = 0; i < 3; i++) begin
            bus_write(TADDR, tbl[i].timing);
            bus_write(CADDR, tbl[i].ctrl);
            rec_seen = 0;
            done_seen = 0;
            gen_sweep(tbl[i].settle, tbl[i].gap, tbl[i].n, 1'b0);
            run_q();
            check($sformatf("rec_cycles_%0d", i), rec_seen, 16 * tbl[i].n);
            check($sformatf("done_pulses_%0d", i), done_seen, 1);
        end

        // External trigger: hold in WAIT_TRIG, then fire.
        bus_write(TADDR, 32'h0002_0003);
        bus_write(CADDR, 32'h0000_0105);
        push_n(2, pk(1, 1, 0, 0, 0, 0));
        push_n(10, pk(1, 0, 0, 0, 0, 0));
        run_q();
        ext_trigger = 1'b1;
        found = 1'b0;
        k = 0;
        while (!found && k < 20) begin
            step();
            k++;
            if (last_rec) found = 1'b1;
        end
        total++;
        if (!(k >= 8 && k <= 9)) begin
            bad++;
            $display("FAIL trig_latency got=%0d exp=8..9", k);
        end
        push_n(15, pk(1, 0, 1, 0, 0, 0));
        push_n(1, pk(1, 0, 0, 1, 0, 0));
        push_n(2, pk(1, 0, 0, 0, 0, 1));
        push_n(1, pk(1, 0, 0, 0, 1, 1));
        push_n(10, pk(0, 0, 0, 0, 0, 1));
        for (int i = 0; exp_q.size() > 0; i++) begin
            // Second edge mid-RECORD, third edge while idle: both ignored.
            if (i == 3 || i == 22) ext_trigger = 1'b0;
            if (i == 7 || i == 25) ext_trigger = 1'b1;
            step();
        end
        ext_trigger = 1'b0;

        // Continuous: two full sweeps, then abort mid-RECORD of the third.
        bus_write(CADDR, 32'h0000_0203);
        rec_seen = 0;
        done_seen = 0;
        gen_sweep(3, 2, 2, 1'b1);
        gen_sweep(3, 2, 2, 1'b1);
        k = exp_q.size();
        gen_sweep(3, 2, 2, 1'b1);
        run_prefix(k + 12);
        bus_write(CADDR, 32'h0000_0000);
        push_n(5, pk(0, 0, 0, 0, 0, 0));
        run_q();
        check("cont_done_pulses", done_seen, 2);
        check("cont_rec_cycles", rec_seen, 16 * 4 + 6);

        // Restart during the first GAP cycle.
        bus_write(CADDR, 32'h0000_0301);
        gen_sweep(3, 2, 3, 1'b0);
        run_prefix(24);
        done_seen = 0;
        bus_write(CADDR, 32'h0000_0301);
        gen_sweep(3, 2, 3, 1'b0);
        run_q();
        check("restart_done_pulses", done_seen, 1);

        // Reset mid-SETTLE; registers return to zero.
        bus_write(CADDR, 32'h0000_0301);
        gen_sweep(3, 2, 3, 1'b0);
        run_prefix(5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        push_n(4, pk(0, 0, 0, 0, 0, 0));
        run_q();

        // After reset TIMING is 0: zero-length settle and gap.
        bus_write(CADDR, 32'h0000_0001);
        done_seen = 0;
        gen_sweep(0, 0, 1, 1'b0);
        run_q();
        check("zero_timing_done", done_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
